// File: rtl/pu_layer_sequencer.sv
// pu_layer_sequencer: steps one PU through a full layer of neurons.
// Loads x once, issues one weight set per cycle, streams results out.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           run request, honoured only while idle
//   ld_x            one-cycle load strobe for the x1..x4 register
//   w_addr          weight ROM address (current neuron)
//   mult_write      PU product-register write enable
//   res_valid       PU output a holds the result for res_idx
//   res_idx         neuron index of the presented result
//   res_ready       consumer takes the result this cycle
//   busy            high whenever a run is in progress
//   done            one-cycle pulse when the layer completes
module pu_layer_sequencer #(
    parameter int NEURON_CNT = 8,
    parameter int IDX_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ld_x,
    output logic [IDX_W-1:0] w_addr,
    output logic             mult_write,
    output logic             res_valid,
    output logic [IDX_W-1:0] res_idx,
    input  logic             res_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        FIN
    } state_t;

    localparam logic [IDX_W:0] CNT_END = (IDX_W+1)'(NEURON_CNT);
    localparam logic [IDX_W:0] CNT_ONE = (IDX_W+1)'(1);

    state_t           state;
    // One extra bit so a full 2^IDX_W layer does not wrap to zero.
    logic [IDX_W:0]   issue_cnt;
    logic             pipe_valid;
    logic [IDX_W-1:0] pipe_idx;

    logic in_run;
    logic cnt_left;
    logic slot_free;
    logic issue;
    logic run_exit;

    assign in_run    = (state == RUN);
    assign cnt_left  = (issue_cnt < CNT_END);
    // The product register may only be overwritten once its result
    // has been taken, otherwise PU output a would change under the
    // consumer.
    assign slot_free = !pipe_valid || res_ready;
    assign issue     = in_run && cnt_left && slot_free;
    assign run_exit  = in_run && !cnt_left && slot_free;

    assign mult_write = issue;
    assign w_addr     = in_run ? issue_cnt[IDX_W-1:0] : '0;
    assign res_valid  = in_run && pipe_valid;
    assign res_idx    = in_run ? pipe_idx : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            issue_cnt  <= '0;
            pipe_valid <= 1'b0;
            pipe_idx   <= '0;
            ld_x       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            ld_x <= 1'b0;
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        ld_x  <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    state      <= RUN;
                    issue_cnt  <= '0;
                    pipe_valid <= 1'b0;
                end
                RUN: begin
                    if (issue) begin
                        issue_cnt  <= issue_cnt + CNT_ONE;
                        pipe_valid <= 1'b1;
                        pipe_idx   <= issue_cnt[IDX_W-1:0];
                    end else if (res_ready) begin
                        pipe_valid <= 1'b0;
                    end
                    if (run_exit) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pu_layer_sequencer.sv
// tb_pu_layer_sequencer: directed and random runs on two instances
// (4-neuron and 1-neuron layers) against a transaction-level model.
module tb_pu_layer_sequencer;

    localparam int IW = 8;

    logic clk;
    logic rst;
    logic start;
    logic res_ready;

    logic          ld_x_s      [2];
    logic [IW-1:0] w_addr_s    [2];
    logic          mult_wr_s   [2];
    logic          res_valid_s [2];
    logic [IW-1:0] res_idx_s   [2];
    logic          busy_s      [2];
    logic          done_s      [2];

    int n_chk = 0;
    int n_err = 0;

    // Model: phase 0 idle, 1 load, 2 run, 3 fin.
    // issued/delivered counts; the presented result is always the
    // next undelivered index.
    int m_ph  [2] = '{0, 0};
    int m_iss [2] = '{0, 0};
    int m_del [2] = '{0, 0};

    int scn_c = -1;
    int first_done [2];
    int last_done  [2];
    int n_done     [2];
    int n_ld       [2];

    pu_layer_sequencer #(.NEURON_CNT(4), .IDX_W(IW)) u_n4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ld_x       (ld_x_s[0]),
        .w_addr     (w_addr_s[0]),
        .mult_write (mult_wr_s[0]),
        .res_valid  (res_valid_s[0]),
        .res_idx    (res_idx_s[0]),
        .res_ready  (res_ready),
        .busy       (busy_s[0]),
        .done       (done_s[0])
    );

    pu_layer_sequencer #(.NEURON_CNT(1), .IDX_W(IW)) u_n1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ld_x       (ld_x_s[1]),
        .w_addr     (w_addr_s[1]),
        .mult_write (mult_wr_s[1]),
        .res_valid  (res_valid_s[1]),
        .res_idx    (res_idx_s[1]),
        .res_ready  (res_ready),
        .busy       (busy_s[1]),
        .done       (done_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input bit s, input bit r, input bit rd);
        @(posedge clk);
        #1;
        start     = s;
        rst       = r;
        res_ready = rd;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            int  n;
            bit  run;
            bit  pend;
            bit  iss;
            string sfx;
            n    = (d == 0) ? 4 : 1;
            sfx  = $sformatf("[n%0d]", n);
            run  = (m_ph[d] == 2);
            pend = (m_iss[d] > m_del[d]);
            iss  = run && (m_iss[d] < n) && (!pend || rd);

            check({"busy", sfx}, int'(busy_s[d]), int'(m_ph[d] != 0));
            check({"ld_x", sfx}, int'(ld_x_s[d]), int'(m_ph[d] == 1));
            check({"done", sfx}, int'(done_s[d]), int'(m_ph[d] == 3));
            check({"mult_write", sfx}, int'(mult_wr_s[d]), int'(iss));
            check({"res_valid", sfx}, int'(res_valid_s[d]),
                  int'(run && pend));
            if (run)
                check({"w_addr", sfx}, int'(w_addr_s[d]), m_iss[d] % 256);
            if (run && pend)
                check({"res_idx", sfx}, int'(res_idx_s[d]), m_del[d]);

            if (scn_c >= 0) begin
                if (done_s[d] === 1'b1) begin
                    if (first_done[d] < 0) first_done[d] = scn_c;
                    last_done[d] = scn_c;
                    n_done[d]++;
                end
                if (ld_x_s[d] === 1'b1) n_ld[d]++;
            end

            if (r) begin
                m_ph[d]  = 0;
                m_iss[d] = 0;
                m_del[d] = 0;
            end else begin
                case (m_ph[d])
                    0: if (s) m_ph[d] = 1;
                    1: begin
                        m_ph[d]  = 2;
                        m_iss[d] = 0;
                        m_del[d] = 0;
                    end
                    2: begin
                        bit fin;
                        fin = (m_iss[d] == n) && (!pend || rd);
                        if (pend && rd) m_del[d]++;
                        if (iss) m_iss[d]++;
                        if (fin) m_ph[d] = 3;
                    end
                    default: m_ph[d] = 0;
                endcase
            end
        end
    endtask

    task automatic scn(input string nm, input int len,
                       input bit [31:0] smask, input bit [31:0] stall,
                       input bit [31:0] rmask,
                       input int fd0, input int ld0, input int nd0,
                       input int fd1, input int ld1, input int nd1);
        for (int d = 0; d < 2; d++) begin
            first_done[d] = -1;
            last_done[d]  = -1;
            n_done[d]     = 0;
            n_ld[d]       = 0;
        end
        for (int c = 0; c < len; c++) begin
            scn_c = c;
            step(smask[c], rmask[c], !stall[c]);
        end
        scn_c = -1;
        check({nm, ".first_done[n4]"}, first_done[0], fd0);
        check({nm, ".last_done[n4]"}, last_done[0], ld0);
        check({nm, ".n_done[n4]"}, n_done[0], nd0);
        check({nm, ".first_done[n1]"}, first_done[1], fd1);
        check({nm, ".last_done[n1]"}, last_done[1], ld1);
        check({nm, ".n_done[n1]"}, n_done[1], nd1);
        check({nm, ".n_ld[n4]"}, n_ld[0], (nd0 > 1) ? nd0 : 1);
        check({nm, ".n_ld[n1]"}, n_ld[1], (nd1 > 1) ? nd1 : 1);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        res_ready = 1'b0;

        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        scn("basic", 12, 32'h1, 32'h0, 32'h0, 7, 7, 1, 4, 4, 1);
        scn("stall", 14, 32'h1, 32'h30, 32'h0, 9, 9, 1, 4, 4, 1);
        scn("ign_start", 12, 32'h15, 32'h0, 32'h0, 7, 7, 1, 4, 4, 1);
        scn("abort", 10, 32'h1, 32'h0, 32'h10, -1, -1, 0, 4, 4, 1);
        scn("rerun", 12, 32'h1, 32'h0, 32'h0, 7, 7, 1, 4, 4, 1);
        scn("b2b", 20, 32'h101, 32'h0, 32'h0, 7, 15, 2, 4, 12, 2);

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) == 0,
                 $urandom_range(0, 149) == 0,
                 $urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
